// File: rtl/mem_dump_ctrl.sv
// Dumps a contiguous data-memory region over a valid/ready port while holding the CPU halted.
// Optional build macro MEM_DUMP_CHECKSUM_EN adds a running checksum of the words that were accepted.
module mem_dump_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              cpu_halt_req,
  input  logic              cpu_halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // state   | meaning
  // IDLE    | waiting for start; the memory port is not in use
  // HALT    | CPU halt requested; waiting for cpu_halted
  // READ    | one-cycle read strobe at the address counter
  // WAIT    | counting down the memory read latency
  // PRESENT | word held on dump_* until the consumer takes it
  // DONE    | one-cycle done pulse; halt request released afterwards
  typedef enum logic [2:0] {IDLE, HALT, READ, WAIT, PRESENT, DONE} stateT;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  stateT             state;
  logic [ADDR_W-1:0] addrCnt;
  logic [ADDR_W-1:0] endReg;
  logic [2:0]        latCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addrCnt      <= '0;
      endReg       <= '0;
      latCnt       <= '0;
      cpu_halt_req <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      dump_valid   <= 1'b0;
      dump_addr    <= '0;
      dump_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else if (abort && state != IDLE) begin
      // Abort drops any in-flight read; the checksum keeps its partial value.
      state        <= IDLE;
      cpu_halt_req <= 1'b0;
      mem_rd_en    <= 1'b0;
      dump_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            addrCnt      <= start_addr;
            endReg       <= end_addr;
            cpu_halt_req <= 1'b1;
            busy         <= 1'b1;
            state        <= HALT;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum     <= '0;
`endif
          end
        end
        HALT: begin
          if (cpu_halted) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addrCnt;
            state     <= READ;
          end
        end
        READ: begin
          mem_rd_en <= 1'b0;
          latCnt    <= LAT_LOAD;
          state     <= WAIT;
        end
        WAIT: begin
          if (latCnt == 3'd0) begin
            dump_data  <= mem_rd_data;
            dump_addr  <= addrCnt;
            dump_valid <= 1'b1;
            state      <= PRESENT;
          end else begin
            latCnt <= latCnt - 3'd1;
          end
        end
        PRESENT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum   <= checksum + dump_data;
`endif
            if (addrCnt == endReg) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Counter wraps naturally, so start_addr > end_addr walks through zero.
              addrCnt   <= addrCnt + 1'b1;
              mem_addr  <= addrCnt + 1'b1;
              mem_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end
        DONE: begin
          done         <= 1'b0;
          cpu_halt_req <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: directed dumps against a queue-based reference of the words a dump must deliver.
// Build with MEM_DUMP_CHECKSUM_EN defined to also exercise the checksum output.
module tb_mem_dump_ctrl;

  localparam int RD_LAT = 1;

  logic        clk;
  logic        reset;
  logic        start, abort;
  logic [15:0] start_addr, end_addr;
  logic        cpu_halt_req, cpu_halted;
  logic        mem_rd_en;
  logic [15:0] mem_addr, mem_rd_data;
  logic        dump_valid, dump_ready;
  logic [15:0] dump_addr, dump_data;
  logic        busy, done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [15:0] checksum, checksum3;
`endif

  logic        start3, abort3;
  logic [15:0] start_addr3, end_addr3;
  logic        cpu_halt_req3, cpu_halted3;
  logic        mem_rd_en3;
  logic [15:0] mem_addr3, mem_rd_data3;
  logic        dump_valid3, dump_ready3;
  logic [15:0] dump_addr3, dump_data3;
  logic        busy3, done3;

  mem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr),
    .cpu_halt_req(cpu_halt_req), .cpu_halted(cpu_halted),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  mem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3),
    .start_addr(start_addr3), .end_addr(end_addr3),
    .cpu_halt_req(cpu_halt_req3), .cpu_halted(cpu_halted3),
    .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .mem_rd_data(mem_rd_data3),
    .dump_valid(dump_valid3), .dump_ready(dump_ready3),
    .dump_addr(dump_addr3), .dump_data(dump_data3),
    .busy(busy3), .done(done3)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory, CPU and consumer models
  logic [15:0] memArr [65536];
  logic        pipeV;
  logic [15:0] pipeA;
  logic [2:0]  pV3;
  logic [15:0] pA3 [3];
  logic [1:0]  haltPipe;
  logic        dropHalt, bpMode, bpReady, readyLevel;
  int          bpCnt;

  always @(posedge clk) begin
    pipeV    <= mem_rd_en;
    pipeA    <= mem_addr;
    pV3      <= {pV3[1:0], mem_rd_en3};
    pA3[0]   <= mem_addr3;
    pA3[1]   <= pA3[0];
    pA3[2]   <= pA3[1];
    haltPipe <= {haltPipe[0], cpu_halt_req};
  end

  assign mem_rd_data  = pipeV  ? memArr[pipeA]  : 16'hDEAD;
  assign mem_rd_data3 = pV3[2] ? memArr[pA3[2]] : 16'hDEAD;
  assign cpu_halted   = haltPipe[1] & ~dropHalt;
  assign cpu_halted3  = cpu_halt_req3;
  assign dump_ready   = bpMode ? bpReady : readyLevel;
  assign dump_ready3  = 1'b1;

  // Backpressure consumer: ready only after valid has waited 5 cycles.
  initial begin
    bpReady = 1'b0;
    bpCnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bpReady) begin
        bpReady = 1'b0;
        bpCnt   = 0;
      end else if (bpMode && dump_valid) begin
        bpCnt++;
        if (bpCnt >= 5) bpReady = 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a queue of addresses still owed by the current dump.
  logic [15:0] expQ[$];
  logic [15:0] gotAddr[$];
  logic [15:0] gotData[$];
  logic        expBusy, expDone, prevValid, prevReady, prevHs;
  logic [15:0] prevAddr, prevData, expCks;
  int          cyc, rdCyc, rdSinceAcc, rdCnt, doneCnt;

  initial begin
    logic nb, nd, hs;
    logic [15:0] a;
    expBusy = 0; expDone = 0; prevValid = 0; prevReady = 0; prevHs = 0;
    prevAddr = 0; prevData = 0; expCks = 0;
    cyc = 0; rdCyc = 0; rdSinceAcc = 0; rdCnt = 0; doneCnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        expBusy = 0; expDone = 0; prevValid = 0; prevHs = 0; expCks = 0;
        rdSinceAcc = 0;
        expQ.delete();
      end else begin
        chk("busy", busy, expBusy);
        chk("cpu_halt_req", cpu_halt_req, expBusy);
        chk("done", done, expDone);
`ifdef MEM_DUMP_CHECKSUM_EN
        chk("checksum", checksum, expCks);
`endif
        if (done) doneCnt++;
        if (!expBusy) begin
          chk("idle_valid", dump_valid, 0);
          chk("idle_rd_en", mem_rd_en, 0);
        end
        if (prevHs) chk("valid_drop", dump_valid, 0);
        if (prevValid && !prevReady && dump_valid) begin
          chk("hold_addr", dump_addr, prevAddr);
          chk("hold_data", dump_data, prevData);
        end
        if (mem_rd_en) begin
          rdCnt++;
          chk("rd_q_nonempty", expQ.size() != 0, 1);
          if (expQ.size() != 0) chk("rd_addr", mem_addr, expQ[0]);
          chk("rd_once", rdSinceAcc, 0);
          rdSinceAcc = 1;
          rdCyc = cyc;
        end
        if (dump_valid && !prevValid) chk("rd_to_valid", cyc - rdCyc, RD_LAT + 1);

        nb = expBusy; nd = 0; hs = 0;
        if (expDone) nb = 0;
        if (abort && expBusy) begin
          nb = 0;
          expQ.delete();
          rdSinceAcc = 0;
        end else if (dump_valid && dump_ready) begin
          hs = 1;
          chk("acc_q_nonempty", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            chk("acc_addr", dump_addr, expQ[0]);
            chk("acc_data", dump_data, memArr[expQ[0]]);
            void'(expQ.pop_front());
          end
          chk("acc_one_read", rdSinceAcc, 1);
          rdSinceAcc = 0;
          gotAddr.push_back(dump_addr);
          gotData.push_back(dump_data);
          expCks = expCks + dump_data;
          if (expQ.size() == 0) nd = 1;
        end
        if (!expBusy && start && !abort) begin
          nb = 1;
          expCks = 0;
          expQ.delete();
          a = start_addr;
          forever begin
            expQ.push_back(a);
            if (a == end_addr) break;
            a = a + 16'd1;
          end
        end
        expBusy = nb; expDone = nd; prevHs = hs;
        prevValid = dump_valid; prevReady = dump_ready;
        prevAddr = dump_addr; prevData = dump_data;
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic startDump(input logic [15:0] sa, input logic [15:0] ea);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    cyc1();
    start      = 1'b0;
  endtask

  task automatic waitDone(input string name, input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (doneCnt != d0) break;
      cyc1();
    end
    chk(name, doneCnt - d0, 1);
    repeat (2) cyc1();
  endtask

  task automatic waitValid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dump_valid) break;
      cyc1();
    end
    chk(name, dump_valid, 1);
  endtask

  task automatic clearLog();
    gotAddr.delete();
    gotData.delete();
    rdCnt = 0;
  endtask

  initial begin
    int d0, c0;
    for (int i = 0; i < 65536; i++) memArr[i] = 16'(i) ^ 16'hA5A5;
    reset = 1'b0; start = 0; abort = 0; start_addr = 0; end_addr = 0;
    start3 = 0; abort3 = 0; start_addr3 = 0; end_addr3 = 0;
    readyLevel = 1; bpMode = 0; dropHalt = 0;
    repeat (3) cyc1();
    chk("rst_busy", busy, 0);
    chk("rst_halt", cpu_halt_req, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dump_data", dump_data, 0);
    reset = 1'b1;
    repeat (2) cyc1();

    // basic 4-word dump
    clearLog(); d0 = doneCnt;
    startDump(16'h0010, 16'h0013);
    waitDone("basic_done", d0, 200);
    chk("basic_words", gotData.size(), 4);
    if (gotData.size() == 4) begin
      chk("basic_d0", gotData[0], 16'hA5B5);
      chk("basic_d1", gotData[1], 16'hA5B4);
      chk("basic_d2", gotData[2], 16'hA5B7);
      chk("basic_d3", gotData[3], 16'hA5B6);
    end
    chk("basic_halt_low", cpu_halt_req, 0);

    // backpressure, with cpu_halted dropping mid-dump
    clearLog(); d0 = doneCnt; bpMode = 1;
    startDump(16'h0040, 16'h0041);
    waitValid("bp_valid", 50);
    dropHalt = 1;
    waitDone("bp_done", d0, 300);
    chk("bp_reads", rdCnt, 2);
    chk("bp_words", gotAddr.size(), 2);
    if (gotAddr.size() == 2) chk("bp_a1", gotAddr[1], 16'h0041);
    bpMode = 0; dropHalt = 0;
    repeat (3) cyc1();

    // wrap through zero
    clearLog(); d0 = doneCnt;
    startDump(16'hFFFE, 16'h0001);
    waitDone("wrap_done", d0, 300);
    chk("wrap_words", gotAddr.size(), 4);
    if (gotAddr.size() == 4) begin
      chk("wrap_a0", gotAddr[0], 16'hFFFE);
      chk("wrap_a1", gotAddr[1], 16'hFFFF);
      chk("wrap_a2", gotAddr[2], 16'h0000);
      chk("wrap_a3", gotAddr[3], 16'h0001);
    end

    // single word
    clearLog(); d0 = doneCnt;
    startDump(16'h1234, 16'h1234);
    waitDone("single_done", d0, 100);
    chk("single_words", gotAddr.size(), 1);

    // abort in the 3rd PRESENT of a 10-word dump
    clearLog(); d0 = doneCnt;
    startDump(16'h0100, 16'h0109);
    for (int i = 0; i < 200; i++) begin
      if (gotAddr.size() >= 2) break;
      cyc1();
    end
    readyLevel = 0;
    waitValid("abort_valid", 50);
    abort = 1;
    cyc1();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid_off", dump_valid, 0);
    chk("abort_halt", cpu_halt_req, 0);
    readyLevel = 1;
    repeat (20) cyc1();
    chk("abort_no_done", doneCnt, d0);
    chk("abort_words", gotAddr.size(), 2);

    // asynchronous reset while waiting on a read
    d0 = doneCnt;
    startDump(16'h0200, 16'h0205);
    for (int i = 0; i < 50; i++) begin
      if (mem_rd_en) break;
      cyc1();
    end
    chk("rst_rd_seen", mem_rd_en, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_halt", cpu_halt_req, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_daddr", dump_addr, 0);
    chk("arst_rd", mem_rd_en, 0);
    repeat (2) cyc1();
    reset = 1'b1;
    repeat (10) cyc1();
    chk("arst_no_done", doneCnt, d0);

    // start while busy is ignored
    clearLog(); d0 = doneCnt;
    startDump(16'h0300, 16'h0302);
    repeat (4) cyc1();
    startDump(16'h0400, 16'h0410);
    waitDone("ign_done", d0, 300);
    chk("ign_words", gotAddr.size(), 3);
    if (gotAddr.size() == 3) chk("ign_last", gotAddr[2], 16'h0302);

    // start and abort together in idle
    start = 1; abort = 1;
    cyc1();
    start = 0; abort = 0;
    repeat (3) cyc1();
    chk("sa_idle_busy", busy, 0);

    // RD_LAT=3 instance: rd strobe to valid is 4 cycles
    start_addr3 = 16'h0020; end_addr3 = 16'h0020; start3 = 1;
    cyc1();
    start3 = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd_en3) break;
      cyc1();
    end
    chk("lat3_rd", mem_rd_en3, 1);
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (dump_valid3) break;
      cyc1();
      c0++;
    end
    chk("lat3_cycles", c0, 4);
    chk("lat3_data", dump_data3, 16'hA585);
    chk("lat3_addr", dump_addr3, 16'h0020);
    repeat (4) cyc1();
    chk("lat3_idle", busy3, 0);

`ifdef MEM_DUMP_CHECKSUM_EN
    memArr[16'h0500] = 16'hFFFF;
    memArr[16'h0501] = 16'h0002;
    d0 = doneCnt;
    startDump(16'h0500, 16'h0501);
    waitDone("cks_done", d0, 200);
    chk("cks_value", checksum, 16'h0001);
`endif

    repeat (3) cyc1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
